// File: rtl/led_pwm_ctrl.sv
// led_pwm_ctrl: picorv32 native-bus PWM LED controller.
// Double-buffered 8-bit duty per LED over a prescaled 256-step period.
module led_pwm_ctrl #(
  parameter int          NO_OF_LEDS = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h0200_0010
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_valid,
  input  logic [31:0]           mem_addr,
  input  logic [31:0]           mem_wdata,
  input  logic [3:0]            mem_wstrb,
  output logic                  sel_ready,
  output logic [31:0]           sel_rdata,
  output logic [NO_OF_LEDS-1:0] led
);

  localparam logic [1:0] OFS_CTRL = 2'd0;
  localparam logic [1:0] OFS_PRE  = 2'd1;
  localparam logic [1:0] OFS_DUTY = 2'd2;
  localparam logic [1:0] OFS_STAT = 2'd3;

  function automatic logic [3:0] duty_mask();
    logic [3:0] m;
    m = '0;
    for (int i = 0; i < 4; i++)
      if (i < NO_OF_LEDS) m[i] = 1'b1;
    return m;
  endfunction

  localparam logic [3:0] DMASK = duty_mask();

  logic             enable;
  logic [15:0]      prescale;
  logic [3:0][7:0]  shadow;
  logic [3:0][7:0]  active;
  logic [15:0]      pre_cnt;
  logic [7:0]       pwm_cnt;

  logic             hit;
  logic [1:0]       ofs;
  logic             wr;
  logic             wr_ctrl;
  logic             wr_pre;
  logic             wr_duty;
  logic             sync_now;
  logic             tick;
  logic             wrap;
  logic             pending;
  logic [31:0]      rd_word;
  logic [NO_OF_LEDS-1:0] led_next;
  logic             unused_addr;

  assign hit     = mem_valid &&
                   (mem_addr[31:4] == BASE_ADDR[31:4]);
  assign ofs     = mem_addr[3:2];
  assign wr      = sel_ready && hit && (mem_wstrb != 4'b0000);
  assign wr_ctrl = wr && (ofs == OFS_CTRL);
  assign wr_pre  = wr && (ofs == OFS_PRE);
  assign wr_duty = wr && (ofs == OFS_DUTY);

  assign sync_now = wr_ctrl && mem_wstrb[0] && mem_wdata[1];
  assign tick     = enable && (pre_cnt == prescale);
  assign wrap     = tick && (pwm_cnt == 8'hFF);
  assign pending  = (shadow != active);

  assign unused_addr = ^mem_addr[1:0];

  // one-cycle ready pulse; a held valid re-arms every second cycle
  always_ff @(posedge clk) begin
    if (reset) sel_ready <= 1'b0;
    else       sel_ready <= hit && !sel_ready;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      enable   <= 1'b0;
      prescale <= '0;
    end else begin
      if (wr_ctrl && mem_wstrb[0])
        enable <= mem_wdata[0];
      if (wr_pre) begin
        if (mem_wstrb[0]) prescale[7:0]  <= mem_wdata[7:0];
        if (mem_wstrb[1]) prescale[15:8] <= mem_wdata[15:8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow <= '0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (wr_duty && mem_wstrb[i] && DMASK[i])
          shadow[i] <= mem_wdata[8*i +: 8];
    end
  end

  // a same-cycle duty write stays pending: NBA loads the old shadow
  always_ff @(posedge clk) begin
    if (reset)                active <= '0;
    else if (sync_now || wrap) active <= shadow;
  end

  // pre_cnt free-runs through 0xFFFF if prescale drops below it
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
    end else if (!enable || sync_now) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
      pwm_cnt <= pwm_cnt + 8'd1;
    end else begin
      pre_cnt <= pre_cnt + 16'd1;
    end
  end

  always_comb begin
    led_next = '0;
    for (int i = 0; i < NO_OF_LEDS; i++)
      led_next[i] = enable && (pwm_cnt < active[i]);
  end

  always_ff @(posedge clk) begin
    if (reset) led <= '0;
    else       led <= led_next;
  end

  always_comb begin
    rd_word = '0;
    unique case (ofs)
      OFS_CTRL: rd_word = {31'd0, enable};
      OFS_PRE:  rd_word = {16'd0, prescale};
      OFS_DUTY: rd_word = shadow;
      OFS_STAT: rd_word = {15'd0, pending, active[0], pwm_cnt};
      default:  rd_word = '0;
    endcase
  end

  assign sel_rdata = sel_ready ? rd_word : 32'd0;

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// tb_led_pwm_ctrl: directed bench for led_pwm_ctrl.
// Bus reads go through an expected-value queue.
module tb_led_pwm_ctrl;

  localparam logic [31:0] BASE = 32'h0200_0010;
  localparam logic [31:0] A_CTRL = BASE + 32'h0;
  localparam logic [31:0] A_PRE  = BASE + 32'h4;
  localparam logic [31:0] A_DUTY = BASE + 32'h8;
  localparam logic [31:0] A_STAT = BASE + 32'hC;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic        sel_ready;
  logic [31:0] sel_rdata;
  logic [3:0]  led;

  int tests = 0;
  int fails = 0;
  int cnt [4];
  logic [31:0] exp_q [$];

  led_pwm_ctrl #(
    .NO_OF_LEDS(4),
    .BASE_ADDR (BASE)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .mem_valid(mem_valid),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb),
    .sel_ready(sel_ready),
    .sel_rdata(sel_rdata),
    .led      (led)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus(input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] r,
                     output int lat);
    @(negedge clk);
    mem_valid = 1'b1;
    mem_addr  = a;
    mem_wdata = d;
    mem_wstrb = s;
    lat = 0;
    r = '0;
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk); #1;
      if (sel_ready) begin
        lat = n;
        r = sel_rdata;
        break;
      end
    end
    @(posedge clk); #1;
    mem_valid = 1'b0;
    mem_wstrb = '0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] s);
    logic [31:0] r;
    int lat;
    bus(a, d, s, r, lat);
    check("wr_lat", 32'(lat), 32'd1);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp,
                    input logic [31:0] mask, input string tag);
    logic [31:0] r;
    logic [31:0] e;
    int lat;
    exp_q.push_back(exp);
    bus(a, 32'd0, 4'b0000, r, lat);
    e = exp_q.pop_front();
    check({tag, "_lat"}, 32'(lat), 32'd1);
    check(tag, r & mask, e);
  endtask

  task automatic count_hi(input int cycles);
    for (int k = 0; k < 4; k++) cnt[k] = 0;
    repeat (cycles) begin
      @(posedge clk); #1;
      for (int k = 0; k < 4; k++)
        if (led[k]) cnt[k]++;
    end
  endtask

  task automatic nohit(input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input string tag);
    logic any;
    any = 1'b0;
    @(negedge clk);
    mem_valid = 1'b1;
    mem_addr  = a;
    mem_wdata = d;
    mem_wstrb = s;
    repeat (4) begin
      @(posedge clk); #1;
      any = any | sel_ready | (|sel_rdata);
    end
    mem_valid = 1'b0;
    mem_wstrb = '0;
    check(tag, {31'd0, any}, 32'd0);
  endtask

  initial begin
    logic [31:0] r;
    int lat;
    int rdy;

    repeat (3) @(posedge clk);
    #1;
    check("rst_led", {28'd0, led}, 32'd0);
    check("rst_ready", {31'd0, sel_ready}, 32'd0);
    check("rst_rdata", sel_rdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    rd(A_CTRL, 32'd0, 32'hFFFF_FFFF, "rst_ctrl");
    rd(A_PRE,  32'd0, 32'hFFFF_FFFF, "rst_pre");
    rd(A_DUTY, 32'd0, 32'hFFFF_FFFF, "rst_duty");
    rd(A_STAT, 32'd0, 32'hFFFF_FFFF, "rst_stat");
    check("rst_ready_low", {31'd0, sel_ready}, 32'd0);

    wr(A_CTRL, 32'd1, 4'hF);
    wr(A_PRE,  32'd0, 4'hF);
    wr(A_DUTY, 32'h0000_8040, 4'hF);
    wr(A_CTRL, 32'd3, 4'hF);
    count_hi(256);
    check("p0_led0", 32'(cnt[0]), 32'd64);
    check("p0_led1", 32'(cnt[1]), 32'd128);
    check("p0_led23", 32'(cnt[2] + cnt[3]), 32'd0);
    rd(A_CTRL, 32'd1, 32'hFFFF_FFFF, "ctrl_sync_reads0");

    wr(A_CTRL, 32'd3, 4'hF);
    wr(A_DUTY, 32'h0000_FF00, 4'b0010);
    rd(A_DUTY, 32'h0000_FF40, 32'hFFFF_FFFF, "duty_bytewr");
    rd(A_STAT, 32'h0001_4000, 32'h0001_FF00, "pending_set");
    repeat (300) @(posedge clk);
    rd(A_STAT, 32'h0000_4000, 32'h0001_FF00, "pending_clr");
    count_hi(256);
    check("duty255_led1", 32'(cnt[1]), 32'd255);
    check("duty64_led0", 32'(cnt[0]), 32'd64);

    wr(A_PRE,  32'd3, 4'hF);
    wr(A_DUTY, 32'h0000_0002, 4'hF);
    wr(A_CTRL, 32'd3, 4'hF);
    count_hi(1024);
    check("pre3_led0", 32'(cnt[0]), 32'd8);
    check("pre3_led1", 32'(cnt[1]), 32'd0);
    repeat (100) @(posedge clk);
    wr(A_DUTY, 32'h0000_0080, 4'b0001);
    count_hi(600);
    check("midperiod_noglitch", 32'(cnt[0]), 32'd0);
    repeat (400) @(posedge clk);
    count_hi(1024);
    check("newduty_led0", 32'(cnt[0]), 32'd512);
    rd(A_STAT, 32'h0000_8000, 32'h0001_FF00, "stat_applied");

    for (int k = 0; k < 2000 && !led[0]; k++) begin
      @(posedge clk); #1;
    end
    check("led0_hi_wait", {31'd0, led[0]}, 32'd1);
    wr(A_CTRL, 32'd0, 4'hF);
    @(posedge clk); #1;
    check("disable_led", {28'd0, led}, 32'd0);
    rd(A_STAT, 32'h0000_8000, 32'hFFFF_FFFF, "disable_stat");
    wr(A_CTRL, 32'd1, 4'hF);
    bus(A_STAT, 32'd0, 4'b0000, r, lat);
    check("resume_cnt", {31'd0, r[7:0] < 8'd2}, 32'd1);
    check("resume_led0", {31'd0, led[0]}, 32'd1);

    nohit(BASE + 32'h10, 32'd0, 4'b0000, "nohit_rd_hi");
    nohit(BASE + 32'h18, 32'hFFFF_FFFF, 4'hF, "nohit_wr_hi");
    nohit(32'h0200_0000, 32'hFFFF_FFFF, 4'hF, "nohit_wr_lo");
    rd(A_DUTY, 32'h0000_0080, 32'hFFFF_FFFF, "nohit_duty");
    rd(A_CTRL, 32'h0000_0001, 32'hFFFF_FFFF, "nohit_ctrl");

    rdy = 0;
    @(negedge clk);
    mem_valid = 1'b1;
    mem_addr  = A_STAT;
    mem_wstrb = 4'b0000;
    repeat (6) begin
      @(posedge clk); #1;
      if (sel_ready) rdy++;
    end
    mem_valid = 1'b0;
    check("b2b_ready", 32'(rdy), 32'd3);

    @(negedge clk);
    mem_valid = 1'b1;
    mem_addr  = A_PRE;
    mem_wdata = 32'h0000_1234;
    mem_wstrb = 4'hF;
    @(posedge clk); #1;
    check("rstwr_ready_up", {31'd0, sel_ready}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rstwr_ready_drop", {31'd0, sel_ready}, 32'd0);
    mem_valid = 1'b0;
    mem_wstrb = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rstwr_led", {28'd0, led}, 32'd0);
    rd(A_PRE, 32'd0, 32'hFFFF_FFFF, "rstwr_pre");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/led_pwm_ctrl.md
# led_pwm_ctrl

Memory-mapped PWM LED controller on the picorv32 native memory bus, placed directly downstream of the CPU in place of the plain LED register. Firmware programs a prescaler and one 8-bit duty value per LED; the block generates glitch-free PWM waveforms on the board LEDs. Duty updates are double-buffered and take effect only at a PWM period boundary.

## Interface

- NO_OF_LEDS, 4, number of LED outputs; legal range 1..4.
- BASE_ADDR, 32'h0200_0010, word-aligned base address; the block decodes the 4 words BASE_ADDR+0x0..+0xC.

- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- mem_valid  in  1  CPU bus request valid.
- mem_addr  in  32  CPU byte address.
- mem_wdata  in  32  write data.
- mem_wstrb  in  4  byte write strobes; 0 means read.
- sel_ready  out  1  bus ready for this block; top ORs it into mem_ready.
- sel_rdata  out  32  read data; 0 whenever sel_ready is low.
- led  out  NO_OF_LEDS  PWM outputs, registered.

## Operation

- Register map, word offsets:
  - +0x0 CTRL: bit0 enable; bit1 sync_now (write-1 pulse, reads 0); other bits read 0.
  - +0x4 PRESCALE: bits[15:0]; upper bits read 0.
  - +0x8 DUTY: byte i is the shadow duty for LED i; bytes ≥ NO_OF_LEDS read 0 and ignore writes.
  - +0xC STATUS, read-only: [7:0] pwm_cnt, [15:8] active duty LED0, bit16 pending (shadow ≠ active).
- Byte strobes are honoured per byte on all writable registers. Writes to STATUS are acknowledged and ignored.
- Prescaler:
  - pre_cnt counts 0..PRESCALE, and tick=1 when pre_cnt==PRESCALE.
  - On tick, pre_cnt returns to 0.
  - PRESCALE=0 gives tick every cycle.
  - Prescaler and PWM counter run only while enable=1; when enable=0 both hold at 0.
- PWM counter:
  - pwm_cnt is 8 bits and increments on tick, wrapping 255→0.
  - The period is 256 ticks.
- Duty buffering:
  - The active duty is loaded from the shadow duty when tick && pwm_cnt==255 (period wrap).
  - It is also loaded on a CTRL write with sync_now=1, which also clears pre_cnt and pwm_cnt.
  - If a DUTY write and a wrap occur in the same cycle, the old shadow value is loaded and the new value stays pending for the next wrap.
- Outputs:
  - led_next[i] = enable && (pwm_cnt < active_duty[i]).
  - Duty 0 gives a constant 0; duty 255 gives 255/256 high.
  - Disabling forces led to 0 on the next cycle.
- PRESCALE written lower than the current pre_cnt: pre_cnt continues to 0xFFFF, wraps to 0, and then obeys the new value. No tick is generated on that wrap.

## Timing

- Reset values:
  - sel_ready=0, sel_rdata=0, led=0.
  - CTRL, PRESCALE, shadow duty, active duty, pre_cnt, and pwm_cnt are all 0.
- Bus handshake:
  - hit = mem_valid && mem_addr[31:4]==BASE_ADDR[31:4].
  - sel_ready is registered: sel_ready <= hit && !sel_ready. It is high for exactly one cycle, one cycle after hit first rises.
  - A valid held across back-to-back accesses yields ready every second cycle.
- Write commit occurs on the cycle sel_ready=1. The new register value is visible from the next cycle.
- Read data is driven combinationally from current register state while sel_ready=1.
- led is registered: it reflects pwm_cnt/active duty with one cycle of latency.
- Reset asserted mid-access: sel_ready drops on the next edge and the write is not committed. The CPU is also in reset.
- Non-hit addresses:
  - sel_ready and sel_rdata stay 0.
  - No state change occurs.

## Test plan

- Reset then read all four offsets: each returns 0, sel_ready pulses exactly 1 cycle after valid, and led=0.
- Write CTRL=1, PRESCALE=0, DUTY=0x00_00_80_40, then sync_now: over 256 cycles LED0 is high for 64 cycles and LED1 for 128; LED2 and LED3 stay 0.
- Byte write with wstrb=4'b0010 and wdata=0x0000_FF00 to DUTY=0x40: the readback is 0x0000_FF40, and STATUS.pending=1 until the next wrap, then 0.
- PRESCALE=3 with duty0=0x02: the PWM period is 1024 cycles and LED0 is high for 8 cycles per period. There is no glitch when duty changes mid-period; the change applies only after pwm_cnt wraps.
- Clear enable while LED0 is high: led=0 on the next cycle and STATUS.pwm_cnt reads 0. Re-enabling resumes from count 0.
- Access BASE_ADDR+0x10 and 0x0200_0000: sel_ready stays 0 and sel_rdata stays 0. Assert reset mid-write: the target register is unchanged (0).
